// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative multiply/divide engine.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width, input int bpc);
    return $clog2(width / bpc) + 1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration, shift-add for MUL or
// restoring trial-subtract for DIV, on a 2*WIDTH shift register.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shl;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                + (i_acc[0] ? {1'b0, i_opnd} : '0);
  assign w_shl  = i_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff = w_shl - {1'b0, i_opnd};

  // A set top bit of the difference means the trial subtract borrowed.
  always_comb begin
    if (!i_div) begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end else if (w_diff[WIDTH]) begin
      o_acc = {w_shl[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
    end else begin
      o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/iter_muldiv.sv
// iter_muldiv: shared iterative signed/unsigned MUL and DIV for EX,
// returning {hi,lo} with a one-cycle ready pulse.
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int CW  = cnt_width(WIDTH, BITS_PER_CYCLE);
  localparam int NIT = WIDTH / BITS_PER_CYCLE;
  localparam logic [CW-1:0] CNT_LOAD = CW'(NIT);

  state_t             r_state;
  logic               r_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_dz;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic               r_busy;
  logic               r_dzo;

  logic               w_div;
  logic               w_sgn;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH-1:0]   w_lo;
  logic [2*WIDTH-1:0] w_fix;
  logic [2*WIDTH-1:0] w_chain [BITS_PER_CYCLE+1];

  assign w_div   = (op_i == OP_DIVU) || (op_i == OP_DIV);
  assign w_sgn   = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign w_a_neg = w_sgn & opdata1_i[WIDTH-1];
  assign w_b_neg = w_sgn & opdata2_i[WIDTH-1];
  assign w_a_abs = w_a_neg ? -opdata1_i : opdata1_i;
  assign w_b_abs = w_b_neg ? -opdata2_i : opdata2_i;

  assign w_chain[0] = r_acc;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    muldiv_step #(
      .WIDTH (WIDTH)
    ) u_step (
      .i_div  (r_div),
      .i_acc  (w_chain[g]),
      .i_opnd (r_b),
      .o_acc  (w_chain[g+1])
    );
  end

  assign w_hi = r_acc[2*WIDTH-1:WIDTH];
  assign w_lo = r_acc[WIDTH-1:0];

  // Divide-by-zero keeps the raw dividend in the low half of r_acc.
  always_comb begin
    w_fix = r_acc;
    if (r_dz) begin
      w_fix = {w_lo, {WIDTH{1'b1}}};
    end else if (r_div) begin
      w_fix[WIDTH-1:0]       = r_neg_res ? -w_lo : w_lo;
      w_fix[2*WIDTH-1:WIDTH] = r_neg_rem ? -w_hi : w_hi;
    end else if (r_neg_res) begin
      w_fix = -r_acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_div     <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz      <= 1'b0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_dzo     <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_dzo   <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start_i && !annul_i) begin
            r_div     <= w_div;
            r_neg_res <= w_sgn & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            r_neg_rem <= w_a_neg;
            r_cnt     <= CNT_LOAD;
            r_busy    <= 1'b1;
            if (w_div && (opdata2_i == '0)) begin
              r_dz    <= 1'b1;
              r_b     <= '0;
              r_acc   <= {{WIDTH{1'b0}}, opdata1_i};
              r_state <= ST_DONE;
            end else begin
              r_dz    <= 1'b0;
              r_b     <= w_div ? w_b_abs : w_a_abs;
              r_acc   <= {{WIDTH{1'b0}}, (w_div ? w_a_abs : w_b_abs)};
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (annul_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_chain[BITS_PER_CYCLE];
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (!annul_i) begin
            r_result <= w_fix;
            r_ready  <= 1'b1;
            r_dzo    <= r_dz;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign busy_o     = r_busy;
  assign div_zero_o = r_dzo;

endmodule
